uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver: deserialises 8N1 UART bytes on `rxd`, pairs them into 16-bit command words, and presents each word for one cycle on `cmd`. It sits directly upstream of the speed-select switch, which compares `cmd` against fixed codes (16'hC891 selects fast, 16'hC894 selects slow). Between words `cmd` idles at 16'h0000, a value the downstream compare ignores.

## Interface
- `CLK_HZ`, 24_000_000: clock frequency in Hz.
- `BAUD`, 115200: serial bit rate.
- `BIT_DIV`, CLK_HZ/BAUD (truncated, 208): clocks per bit.
- `TIMEOUT_CYC`, 20*BIT_DIV: maximum idle clocks allowed between the two bytes of a word.

- `clk_24m`  in  1  system clock, the only clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  asynchronous UART line, idle high.
- `cmd`  out  16  command word. Valid only while `cmd_valid`=1, otherwise 16'h0000.
- `cmd_valid`  out  1  one-cycle strobe per completed word.
- `frame_err`  out  1  one-cycle strobe on a bad stop bit or an inter-byte timeout.

## Operation
- **Input sync:** `rxd` passes through 2 flops, both reset to 1. All logic uses the synced value `rxs`.
- **Receiver states:** IDLE, START, DATA, STOP.
  - **IDLE:** on a falling edge of `rxs` (previous=1, current=0), go to START and load the bit counter. Call this edge-detect cycle T0.
  - **START:** sample `rxs` at T0+BIT_DIV/2.
    - If 1: false start. Return to IDLE with no strobe.
    - If 0: go to DATA.
  - **DATA:** 8 samples at BIT_DIV spacing, LSB first, shifted into the byte register.
  - **STOP:** sample at T0+BIT_DIV/2+9*BIT_DIV.
    - If 1: the byte is good.
    - If 0: pulse `frame_err`, discard the byte, and clear any pending high byte.
    - In both cases return to IDLE on the same cycle, so the receiver is armed from mid-stop-bit.
- **Word assembly:**
  - A pending flag `have_hi` resets to 0.
  - Good byte with `have_hi`=0: store it as the high byte and set `have_hi`=1.
  - Good byte with `have_hi`=1: on the next cycle drive `cmd`={hi, lo} and `cmd_valid`=1, then clear `have_hi`.
  - First byte received is the MSB, so C8 then 91 gives 16'hC891.
- **Timeout:**
  - While `have_hi`=1 and the receiver is in IDLE, a counter increments. It clears on any state other than IDLE and whenever `have_hi`=0.
  - When it reaches TIMEOUT_CYC: clear `have_hi` and pulse `frame_err`. No word is emitted.
- **Simultaneous events:** a timeout and a start edge on the same cycle are resolved in favour of the start edge. The counter clears and `have_hi` is retained.
- **Reset:** takes effect at any point, including mid-byte. The receiver returns to IDLE, `have_hi`=0, all counters are cleared, and outputs are zeroed. Any partial byte or word is lost.
- **Continuous line low (break):** produces one `frame_err`. No new start is detected until `rxs` has returned to 1.

## Timing
- **Reset values:** `cmd`=16'h0000, `cmd_valid`=0, `frame_err`=0, synchronizer flops=1.
- **Edge detection:** T0 is 2 clocks after the first clock edge that samples `rxd` low.
- **Stop sample** of a byte starting at T0: T0+BIT_DIV/2+9*BIT_DIV, which is T0+1976 at defaults.
- **Output latency:**
  - `cmd_valid` of a word asserts at the second byte's stop sample + 1.
  - `frame_err` for a bad stop bit asserts at stop sample + 1.
  - `frame_err` for a timeout asserts on the cycle after the counter reaches TIMEOUT_CYC.
- **Output registers:** `cmd` and `cmd_valid` change together and are registered. Both strobes are exactly 1 cycle wide.
- **Throughput:** back-to-back bytes with zero idle bits are accepted (minimum byte period 10*BIT_DIV).

## Test plan
- **Reset:** hold `rstn`=0 with `rxd` toggling → all outputs 0, no strobes. Release, then send C8,91 → single `cmd_valid` with `cmd`=16'hC891.
- **Latency:** send C8,94 back-to-back at 115200 → `cmd_valid` exactly once, `cmd`=16'hC894, 1977 clocks after the second byte's T0. `cmd`=0 on the cycles before and after.
- **Framing error:** send C8, then a byte with stop bit 0, then 91 → `frame_err` pulse and no `cmd_valid`. Then send C8,91 → 16'hC891.
- **Timeout:** send C8, idle 20*208+10 clocks, then send 91,C8,94 → `frame_err` once at the timeout. The next word is 16'h91C8; the trailing 94 stays pending.
- **Glitch:** an `rxd` low pulse of 50 clocks → no strobes. The receiver re-arms and the following C8,91 decodes correctly.
- **Reset mid-byte:** assert `rstn` low during the DATA bits of the second byte, release, then send C8,94 → only 16'hC894 is emitted. No stale high byte is used.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that pairs bytes (MSB first) into 16-bit command words.
// Emits a one-cycle cmd/cmd_valid strobe per word and a one-cycle frame_err on bad stop or timeout.
module uart_cmd_rx #(
    parameter int CLK_HZ      = 24_000_000,
    parameter int BAUD        = 115200,
    parameter int BIT_DIV     = CLK_HZ / BAUD,
    parameter int TIMEOUT_CYC = 20 * BIT_DIV
) (
    input  logic        clk_24m,
    input  logic        rstn,
    input  logic        rxd,
    output logic [15:0] cmd,
    output logic        cmd_valid,
    output logic        frame_err
);

    localparam int HALF = BIT_DIV / 2;
    localparam int CW   = $clog2(BIT_DIV + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic          rx_meta_q, rxs_q, rxs_prev_q;
    state_e        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          done_q, bad_q;
    logic          have_hi_q;
    logic [7:0]    hi_q;
    logic [TW-1:0] to_cnt_q;
    logic [15:0]   cmd_q;
    logic          cmd_valid_q, frame_err_q;

    logic fall, start_det, tick, timeout;

    assign fall      = rxs_prev_q & ~rxs_q;
    assign start_det = (state_q == IDLE) && fall;
    assign tick      = (bit_cnt_q == '0);
    assign timeout   = (to_cnt_q == TW'(TIMEOUT_CYC));

    // rxd is asynchronous; the third flop only provides the previous value for edge detection
    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            bad_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q   <= START;
                        bit_cnt_q <= CW'(HALF - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= rxs_q ? IDLE : DATA;
                        bit_cnt_q <= CW'(BIT_DIV - 1);
                        bit_idx_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_cnt_q <= CW'(BIT_DIV - 1);
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                STOP: begin
                    // back to IDLE at mid-stop so a zero-gap following start bit is caught
                    if (tick) begin
                        state_q <= IDLE;
                        done_q  <= rxs_q;
                        bad_q   <= ~rxs_q;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            have_hi_q   <= 1'b0;
            hi_q        <= '0;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // a start edge coinciding with the timeout wins: counter clears, high byte kept
            if (state_q != IDLE || !have_hi_q || start_det || timeout) to_cnt_q <= '0;
            else to_cnt_q <= to_cnt_q + TW'(1);

            if (bad_q) begin
                frame_err_q <= 1'b1;
                have_hi_q   <= 1'b0;
            end else if (done_q) begin
                if (have_hi_q) begin
                    cmd_q       <= {hi_q, shift_q};
                    cmd_valid_q <= 1'b1;
                    have_hi_q   <= 1'b0;
                end else begin
                    hi_q      <= shift_q;
                    have_hi_q <= 1'b1;
                end
            end else if (timeout && !start_det) begin
                frame_err_q <= 1'b1;
                have_hi_q   <= 1'b0;
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed + randomized bench for uart_cmd_rx against a byte-level model of word pairing,
// framing errors and inter-byte timeouts, including exact cmd_valid latency.
module tb_uart_cmd_rx;

    localparam int BIT_DIV     = 208;
    localparam int TIMEOUT_CYC = 20 * BIT_DIV;
    // drive of start bit -> first sampling edge (1) -> T0 (+2) -> cmd_valid (+1977)
    localparam int LAT         = 1980;

    logic        clk_24m = 1'b0;
    logic        rstn    = 1'b0;
    logic        rxd     = 1'b1;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        frame_err;

    uart_cmd_rx dut (
        .clk_24m  (clk_24m),
        .rstn     (rstn),
        .rxd      (rxd),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err)
    );

    always #5 clk_24m = ~clk_24m;

    int cyc = 0;
    always @(posedge clk_24m) cyc <= cyc + 1;

    // observed events
    logic [15:0] got_w[$];
    int          got_t[$];
    int          got_err = 0;
    int          bad_idle = 0;
    int          bad_width = 0;
    logic        prev_v = 1'b0, prev_e = 1'b0;

    always @(negedge clk_24m) begin
        if (cmd_valid) begin
            got_w.push_back(cmd);
            got_t.push_back(cyc);
        end
        if (!cmd_valid && cmd !== 16'h0000) bad_idle <= bad_idle + 1;
        if ((cmd_valid && prev_v) || (frame_err && prev_e)) bad_width <= bad_width + 1;
        if (frame_err) got_err <= got_err + 1;
        prev_v <= cmd_valid;
        prev_e <= frame_err;
    end

    // reference model
    bit          m_have = 1'b0;
    logic [7:0]  m_hi   = 8'h00;
    logic [15:0] exp_w[$];
    int          exp_t[$];
    int          exp_err = 0;
    int          ck = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_24m);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        int t_start;
        rxd = 1'b1;
        idle(gap);
        if (m_have && gap > TIMEOUT_CYC) begin
            exp_err++;
            m_have = 1'b0;
        end
        t_start = cyc;
        rxd = 1'b0;
        idle(BIT_DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT_DIV);
        end
        rxd = stop_ok;
        idle(BIT_DIV);
        if (!stop_ok) begin
            rxd = 1'b1;
            idle(BIT_DIV);
            exp_err++;
            m_have = 1'b0;
        end else if (!m_have) begin
            m_hi   = b;
            m_have = 1'b1;
        end else begin
            exp_w.push_back({m_hi, b});
            exp_t.push_back(t_start + LAT);
            m_have = 1'b0;
        end
    endtask

    task automatic check_scene(input string tag);
        chk({tag, " words"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = ck; i < exp_w.size() && i < got_w.size(); i++) begin
            chk({tag, " cmd"}, 32'(got_w[i]), 32'(exp_w[i]));
            chk({tag, " t"}, 32'(got_t[i]), 32'(exp_t[i]));
        end
        ck = exp_w.size();
        chk({tag, " frame_err"}, 32'(got_err), 32'(exp_err));
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        idle(4);
        chk({tag, " rst out"}, {15'd0, cmd, frame_err}, 32'd0);
        chk({tag, " rst vld"}, 32'(cmd_valid), 32'd0);
        rstn = 1'b1;
        m_have = 1'b0;
        idle(8);
    endtask

    initial begin
        // reset with the line toggling
        rstn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rxd = 1'($urandom);
            idle(1);
            if (i % 8 == 7) begin
                chk("reset cmd", 32'(cmd), 32'd0);
                chk("reset strobes", {30'd0, cmd_valid, frame_err}, 32'd0);
            end
        end
        rxd = 1'b1;
        idle(5);
        rstn = 1'b1;
        idle(10);
        send_byte(8'hC8, 1'b1, 0);
        send_byte(8'h91, 1'b1, 0);
        idle(5);
        check_scene("reset");

        // latency, back to back
        send_byte(8'hC8, 1'b1, 20);
        send_byte(8'h94, 1'b1, 0);
        idle(5);
        check_scene("latency");

        // framing error then recovery
        send_byte(8'hC8, 1'b1, 10);
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h91, 1'b1, 0);
        idle(5);
        check_scene("framing");
        do_reset("framing");
        send_byte(8'hC8, 1'b1, 0);
        send_byte(8'h91, 1'b1, 0);
        idle(5);
        check_scene("framing recover");

        // inter-byte timeout
        send_byte(8'hC8, 1'b1, 10);
        send_byte(8'h91, 1'b1, TIMEOUT_CYC + 10);
        send_byte(8'hC8, 1'b1, 0);
        send_byte(8'h94, 1'b1, 0);
        idle(5);
        check_scene("timeout");
        do_reset("timeout");

        // glitch shorter than half a bit
        rxd = 1'b0;
        idle(50);
        rxd = 1'b1;
        idle(300);
        check_scene("glitch");
        send_byte(8'hC8, 1'b1, 0);
        send_byte(8'h91, 1'b1, 0);
        idle(5);
        check_scene("glitch recover");

        // break: line held low for many bit times
        send_byte(8'hC8, 1'b1, 10);
        rxd = 1'b0;
        idle(12 * BIT_DIV);
        rxd = 1'b1;
        idle(BIT_DIV);
        exp_err++;
        m_have = 1'b0;
        check_scene("break");

        // reset during data bits of the second byte
        send_byte(8'hC8, 1'b1, 10);
        rxd = 1'b0;
        idle(BIT_DIV);
        for (int i = 0; i < 3; i++) begin
            rxd = (i == 2);
            idle(BIT_DIV);
        end
        idle(100);
        rxd = 1'b1;
        do_reset("midbyte");
        idle(3 * BIT_DIV);
        send_byte(8'hC8, 1'b1, 0);
        send_byte(8'h94, 1'b1, 0);
        idle(5);
        check_scene("midbyte");

        // random bytes, occasional bad stop bits, short gaps
        for (int i = 0; i < 10; i++) begin
            send_byte(8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(0, 300));
        end
        idle(5);
        check_scene("random");

        chk("cmd nonzero while idle", 32'(bad_idle), 32'd0);
        chk("strobe width", 32'(bad_width), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: observed no end of run, expected finish within 150000 cycles");
        $fatal(1);
    end

endmodule
